// File: rtl/pc_stack_counter.sv
// pc_stack_counter
//   Fetch-stage program counter with an integrated return-address stack.
//   Each enabled cycle performs exactly one operation. Priority is
//   ret > call > load > sequential advance by STEP.
//   All PC arithmetic wraps modulo 2^WIDTH.
//   Stack misuse sets sticky error flags. The flags never alter PC or
//   stack behaviour.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   enab       advance enable; 0 = stall (PC/stack hold, op strobes ignored)
//   load       jump to target
//   call       push pc_out+STEP, then jump to target
//   ret        pop top of stack into PC (RESET_PC if stack empty)
//   target     jump/call destination
//   clr_err    clear sticky error flags (a coincident new error wins)
//   pc_out     current PC (registered)
//   sp_out     number of valid stack entries, 0..DEPTH
//   stk_full   sp_out == DEPTH
//   stk_empty  sp_out == 0
//   err_ovf    sticky: call while stack full
//   err_udf    sticky: ret while stack empty

module pc_stack_counter #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 4,
    parameter int STEP     = 1,
    parameter int RESET_PC = 0,
    localparam int SPW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enab,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc_out,
    output logic [SPW-1:0]   sp_out,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             err_ovf,
    output logic             err_udf
);

    // Index width is at least 1 so DEPTH=1 still has a legal array index.
    // The array is sized to the full index range, so reading at sp-1 when
    // sp==0 stays in bounds. That read result is not used.
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_udf_q, err_udf_d;
    logic             push_en;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] stack_q [2**IDXW];

    logic full, empty;

    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign ret_addr = pc_q + WIDTH'(STEP);

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        push_en   = 1'b0;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;

        // Clear first so that a same-cycle error event below overrides it.
        if (clr_err) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end

        if (enab) begin
            if (ret) begin
                if (!empty) begin
                    pc_d = stack_q[IDXW'(sp_q - SPW'(1))];
                    sp_d = sp_q - SPW'(1);
                end else begin
                    pc_d      = WIDTH'(RESET_PC);
                    err_udf_d = 1'b1;
                end
            end else if (call) begin
                pc_d = target;
                if (!full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SPW'(1);
                end else begin
                    err_ovf_d = 1'b1;
                end
            end else if (load) begin
                pc_d = target;
            end else begin
                pc_d = ret_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= WIDTH'(RESET_PC);
            sp_q      <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Stack storage has no reset. Entries at or above sp are never read
    // back, so their contents after reset do not matter.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[IDXW'(sp_q)] <= ret_addr;
        end
    end

    assign pc_out    = pc_q;
    assign sp_out    = sp_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
module tb_pc_stack_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enab, load, call, ret, clr_err;
    logic [4:0] target;
    logic [4:0] pc_out;
    logic [2:0] sp_out;
    logic       stk_full, stk_empty, err_ovf, err_udf;

    int n_chk  = 0;
    int n_pass = 0;

    pc_stack_counter #(.WIDTH(5), .DEPTH(4), .STEP(1), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .enab      (enab),
        .load      (load),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .clr_err   (clr_err),
        .pc_out    (pc_out),
        .sp_out    (sp_out),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one op, advance one clock edge, and leave the outputs settled.
    task automatic op(input logic e, input logic l, input logic c, input logic r,
                      input logic [4:0] t, input logic ce);
        enab = e; load = l; call = c; ret = r; target = t; clr_err = ce;
        @(posedge clk);
        #1;
        enab = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int pc, input int sp,
                             input int ovf, input int udf);
        chk({tag, ".pc"},  int'(pc_out),  pc);
        chk({tag, ".sp"},  int'(sp_out),  sp);
        chk({tag, ".ovf"}, int'(err_ovf), ovf);
        chk({tag, ".udf"}, int'(err_udf), udf);
    endtask

    initial begin
        int exp_seq[3];
        int rets[4];
        rst = 1'b1; enab = 0; load = 0; call = 0; ret = 0; clr_err = 0; target = '0;
        #12;
        chk_state("rst", 0, 0, 0, 0);
        chk("rst.empty", int'(stk_empty), 1);
        chk("rst.full",  int'(stk_full),  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: plain advance from reset
        for (int i = 1; i <= 3; i++) begin
            op(1, 0, 0, 0, 5'd0, 0);
            chk($sformatf("adv%0d.pc", i), int'(pc_out), i);
        end
        chk("adv.sp", int'(sp_out), 0);
        chk("adv.empty", int'(stk_empty), 1);

        // 2: wrap 30 -> 31 -> 0 -> 1
        op(1, 1, 0, 0, 5'd30, 0);
        chk("load30.pc", int'(pc_out), 30);
        exp_seq = '{31, 0, 1};
        for (int i = 0; i < 3; i++) begin
            op(1, 0, 0, 0, 5'd0, 0);
            chk($sformatf("wrap%0d.pc", i), int'(pc_out), exp_seq[i]);
        end
        chk("wrap.ovf", int'(err_ovf), 0);
        chk("wrap.udf", int'(err_udf), 0);

        // 3: call / advance / ret
        op(1, 1, 0, 0, 5'd5, 0);
        op(1, 0, 1, 0, 5'd20, 0);
        chk_state("call20", 20, 1, 0, 0);
        chk("call20.empty", int'(stk_empty), 0);
        op(1, 0, 0, 0, 5'd0, 0);
        op(1, 0, 0, 0, 5'd0, 0);
        chk("adv22.pc", int'(pc_out), 22);
        op(1, 0, 0, 1, 5'd0, 0);
        chk_state("ret6", 6, 0, 0, 0);

        // 4: fill the stack, overflow, then unwind (pushed 7,11,13,15)
        op(1, 0, 1, 0, 5'd10, 0);
        op(1, 0, 1, 0, 5'd12, 0);
        op(1, 0, 1, 0, 5'd14, 0);
        chk("call3.full", int'(stk_full), 0);
        op(1, 0, 1, 0, 5'd16, 0);
        chk_state("call4", 16, 4, 0, 0);
        chk("call4.full", int'(stk_full), 1);
        op(1, 0, 1, 0, 5'd9, 0);
        chk_state("ovf", 9, 4, 1, 0);
        rets = '{15, 13, 11, 7};
        for (int i = 0; i < 4; i++) begin
            op(1, 0, 0, 1, 5'd0, 0);
            chk($sformatf("unwind%0d.pc", i), int'(pc_out), rets[i]);
            chk($sformatf("unwind%0d.sp", i), int'(sp_out), 3 - i);
        end
        chk("unwind.ovf", int'(err_ovf), 1);

        // 5: underflow, clear, and set-wins-over-clear
        op(1, 0, 0, 1, 5'd0, 0);
        chk_state("udf", 0, 0, 1, 1);
        op(0, 0, 0, 0, 5'd0, 1);
        chk_state("clr", 0, 0, 0, 0);
        op(1, 1, 0, 0, 5'd8, 0);
        op(1, 0, 0, 1, 5'd0, 1);
        chk_state("setwins", 0, 0, 0, 1);
        op(0, 0, 0, 0, 5'd0, 1);
        chk("clr2.udf", int'(err_udf), 0);

        // pushed return address wraps: call at 31 pushes 0
        op(1, 1, 0, 0, 5'd31, 0);
        op(1, 0, 1, 0, 5'd12, 0);
        op(1, 0, 0, 1, 5'd0, 0);
        chk_state("retwrap", 0, 0, 0, 0);

        // 6: stall ignores strobes, priority, async reset mid-chain
        op(1, 1, 0, 0, 5'd3, 0);
        op(0, 1, 1, 1, 5'd25, 0);
        chk_state("stall", 3, 0, 0, 0);
        op(1, 0, 1, 0, 5'd20, 0);
        op(1, 1, 1, 1, 5'd25, 0);
        chk_state("prio", 4, 0, 0, 0);
        op(1, 0, 0, 1, 5'd0, 0);
        op(1, 0, 1, 0, 5'd7, 0);
        chk_state("prerst", 7, 1, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_state("asyncrst", 0, 0, 0, 0);
        chk("asyncrst.empty", int'(stk_empty), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op(1, 0, 0, 1, 5'd0, 0);
        chk_state("postrst", 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
